gate_truth_table_checker: RTL
=============================

Name: gate_truth_table_checker

Overview:
Sequential self-check stage wrapped around the mux-built 2-input gate block. Drives the gate block's a/b inputs through all four input vectors and samples its 6-bit gate result bus after a settle interval. Compares each sample against a golden truth table and reports a per-gate sticky error mask, an error count, the first failing vector and pass/done status to the controller above it.

Parameters:
SETTLE_CYCLES, 1, cycles a/b are held before sampling; legal range 1..15
REPEAT, 1, number of full 4-vector sweeps per run; legal range 1..255

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  run request; sampled only in IDLE
gate_out_i  input  6  result bus from gate block; bit0 OR, bit1 AND, bit2 NAND, bit3 NOR, bit4 XOR, bit5 XNOR
a_o  output  1  registered operand a to gate block
b_o  output  1  registered operand b to gate block
busy  output  1  high from cycle after start accepted until DONE
done  output  1  one-cycle pulse at end of run
pass  output  1  high when last completed run had zero mismatches
err_mask  output  6  sticky OR of mismatching bits over the run
err_count  output  8  number of vectors with any mismatch, saturates at 255
first_fail  output  3  {valid, a, b} of first mismatching vector; 3'b000 if none

Behaviour:
- Reset (rst=1 at edge): state IDLE; a_o=0, b_o=0, busy=0, done=0, pass=0, err_mask=0, err_count=0, first_fail=0; vector and sweep counters 0. Reset mid-run aborts immediately, no done pulse.
- Vector index v={a_o,b_o}, stepping 00,01,10,11.
- Golden table (gate_out bits 5..0): v=00 -> 6'h2C; v=01 -> 6'h15; v=10 -> 6'h15; v=11 -> 6'h23.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 -> clear err_mask/err_count/first_fail/pass, load v=0, sweep=0, settle_cnt=0, go SETTLE. start=0 -> stay.
- SETTLE: busy=1, a_o/b_o held. Increment settle_cnt. At settle_cnt==SETTLE_CYCLES-1, go CHECK.
- CHECK: diff = gate_out_i ^ golden(v). err_mask |= diff.
  - If diff!=0: err_count += 1, saturating at 255; if first_fail[2]==0, capture {1,v}.
  - If v==3 and sweep==REPEAT-1: go DONE.
  - Otherwise: v=v+1 (3 wraps to 0 with sweep+1), reset settle_cnt, go SETTLE. a_o/b_o update at that same edge.
- DONE: done=1 for exactly one cycle; busy=0; pass registered as (err_count==0 including this final check). Then go IDLE.
- pass, err_mask, err_count and first_fail hold their values in IDLE until the next accepted start.
- start while busy or in DONE: ignored, no queuing.
- Latency: start sampled at cycle 0 -> done high at cycle 4*REPEAT*(SETTLE_CYCLES+1)+1. Defaults give cycle 9.
- gate_out_i is sampled only in CHECK; its value in other states is don't-care.

Optional Feature:
GATE_CHECKER_INJECT_EN
- Defined: adds input port inj_mask[5:0]. Comparison uses (gate_out_i ^ inj_mask) in place of gate_out_i, for fault-injection self-test of the checker.
- Undefined: port absent; comparison uses gate_out_i directly. Behaviour otherwise identical.

Decomposition:
- Shared package gate_chk_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - gate bit-index constants GATE_OR=0 .. GATE_XNOR=5
  - golden table constant GOLDEN[4] = {6'h2C, 6'h15, 6'h15, 6'h23}
  - localparam ERR_CNT_W=8
- One natural sub-module, gate_chk_settle_cnt: a loadable down/up settle counter with a terminal flag. All other logic stays in the top.

Test Plan:
- Good DUT (real gate block attached), defaults, start pulse at cycle 0 -> a_o/b_o sequence 00,01,10,11; done at cycle 9; pass=1, err_mask=0, err_count=0, first_fail=000.
- Gate block replaced by stuck bit0=0 (OR broken), REPEAT=1 -> err_mask=6'h01, err_count=3, first_fail=3'b101 (v=01), pass=0.
- SETTLE_CYCLES=3, REPEAT=2, good DUT -> done at cycle 33; a_o/b_o each held 4 cycles per vector; pass=1.
- rst asserted during SETTLE of v=10 -> next cycle all outputs at reset values, no done pulse; a following start runs a clean full sweep.
- Always-mismatch bus (gate_out_i=6'h3F), REPEAT=255, SETTLE_CYCLES=1 -> err_count saturates at 255, err_mask=6'h3F; start pulses during busy are ignored (single done).
- With GATE_CHECKER_INJECT_EN and inj_mask=6'h10 on a good DUT -> err_mask=6'h10, err_count=4, first_fail=3'b100.

Source files
------------

// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int unsigned GATE_OR   = 0;
  localparam int unsigned GATE_AND  = 1;
  localparam int unsigned GATE_NAND = 2;
  localparam int unsigned GATE_NOR  = 3;
  localparam int unsigned GATE_XOR  = 4;
  localparam int unsigned GATE_XNOR = 5;

  localparam int unsigned ERR_CNT_W = 8;

  // Indexed by {a,b}; bits 5..0 = XNOR,XOR,NOR,NAND,AND,OR.
  localparam logic [5:0] GOLDEN [4] = '{6'h2C, 6'h15, 6'h15, 6'h23};

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Controller-side handshake and result bundle of the gate truth-table checker.
interface gate_truth_table_checker_if;
  import gate_chk_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [5:0]           err_mask;
  logic [ERR_CNT_W-1:0] err_count;
  logic [2:0]           first_fail;

  modport master (
    output start,
    input  busy, done, pass, err_mask, err_count, first_fail
  );

  modport slave (
    input  start,
    output busy, done, pass, err_mask, err_count, first_fail
  );
endinterface

// File: rtl/gate_truth_table_checker_settle_cnt.sv
// Settle-interval counter: clears to zero, counts while enabled, flags the last settle cycle.
module gate_chk_settle_cnt #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps the 2-input gate block through all {a,b} vectors and checks its result bus.
// Optional macro GATE_CHECKER_INJECT_EN adds inj_mask[5:0] to corrupt the compared bus.
module gate_truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned REPEAT        = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  gate_truth_table_checker_if.slave   ctrl,
  input  logic [5:0]                  gate_out_i,
`ifdef GATE_CHECKER_INJECT_EN
  input  logic [5:0]                  inj_mask,
`endif
  output logic                        a_o,
  output logic                        b_o
);

  state_e               state_q, state_d;
  logic [1:0]           v_q, v_d;
  logic [7:0]           sweep_q, sweep_d;
  logic [5:0]           err_mask_q, err_mask_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [2:0]           first_fail_q, first_fail_d;
  logic                 pass_q, pass_d;

  logic       settle_clr, settle_en, settle_term;
  logic [5:0] observed, diff;

  gate_chk_settle_cnt #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (settle_clr),
    .en_i   (settle_en),
    .term_o (settle_term)
  );

`ifdef GATE_CHECKER_INJECT_EN
  assign observed = gate_out_i ^ inj_mask;
`else
  assign observed = gate_out_i;
`endif

  assign diff = observed ^ GOLDEN[v_q];

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    sweep_d      = sweep_q;
    err_mask_d   = err_mask_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    settle_clr   = 1'b0;
    settle_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl.start) begin
          err_mask_d   = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          v_d          = '0;
          sweep_d      = '0;
          settle_clr   = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_en = 1'b1;
        if (settle_term)
          state_d = ST_CHECK;
      end
      ST_CHECK: begin
        err_mask_d = err_mask_q | diff;
        if (diff != '0) begin
          if (err_count_q != '1)
            err_count_d = err_count_q + 8'd1;
          if (!first_fail_q[2])
            first_fail_d = {1'b1, v_q};
        end
        if (v_q == 2'd3 && sweep_q == 8'(REPEAT - 1)) begin
          // pass must reflect the final check, so it uses the updated count.
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end else begin
          v_d = v_q + 2'd1;
          if (v_q == 2'd3)
            sweep_d = sweep_q + 8'd1;
          settle_clr = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      v_q          <= '0;
      sweep_q      <= '0;
      err_mask_q   <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      sweep_q      <= sweep_d;
      err_mask_q   <= err_mask_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign a_o             = v_q[1];
  assign b_o             = v_q[0];
  assign ctrl.busy       = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign ctrl.done       = (state_q == ST_DONE);
  assign ctrl.pass       = pass_q;
  assign ctrl.err_mask   = err_mask_q;
  assign ctrl.err_count  = err_count_q;
  assign ctrl.first_fail = first_fail_q;

endmodule
